// File: rtl/legv8_pkg.sv
// Shared ALU opcodes, register constants and forwarding-select encoding
// for the LEGv8 execute-side pipeline blocks.
package legv8_pkg;

  localparam logic [3:0] ALU_AND   = 4'd0;
  localparam logic [3:0] ALU_OR    = 4'd1;
  localparam logic [3:0] ALU_ADD   = 4'd2;
  localparam logic [3:0] ALU_SUB   = 4'd6;
  localparam logic [3:0] ALU_PASSB = 4'd7;

  localparam logic [4:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_MEMWB = 2'd1,
    FWD_EXMEM = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/forward_unit.sv
// Operand forwarding mux for one ALU source: picks the youngest in-flight
// result that targets the source register, never forwarding the zero register.
module forward_unit
  import legv8_pkg::*;
#(
  parameter int N     = 64,
  parameter int RBITS = 5
) (
  input  logic [RBITS-1:0] src,
  input  logic [N-1:0]     rf_data,
  input  logic [RBITS-1:0] exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [N-1:0]     exmem_result,
  input  logic [RBITS-1:0] memwb_rd,
  input  logic             memwb_regwrite,
  input  logic [N-1:0]     memwb_result,
  output logic [N-1:0]     operand,
  output fwd_sel_t         sel
);

  localparam logic [RBITS-1:0] ZERO_REG = '1;

  always_comb begin
    // NOTE: both outputs get a default before any branch, so no path leaves them unassigned (no latch).
    operand = rf_data;
    sel     = FWD_RF;
    // Once src is known not to be the zero register, rd == src implies rd is not it either.
    if (src == ZERO_REG) begin
      operand = '0;
    end else if (exmem_regwrite && (exmem_rd == src)) begin
      operand = exmem_result;
      sel     = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_rd == src)) begin
      operand = memwb_result;
      sel     = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with RAW-hazard forwarding feeding the 64-bit ALU;
// supports stall (hold) and flush (bubble insertion).
module alu_operand_stage
  import legv8_pkg::*;
#(
  parameter int N     = 64,
  parameter int RBITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [RBITS-1:0] id_rn,
  input  logic [RBITS-1:0] id_rm,
  input  logic [RBITS-1:0] id_rd,
  input  logic [N-1:0]     id_rn_data,
  input  logic [N-1:0]     id_rm_data,
  input  logic [N-1:0]     id_imm,
  input  logic             id_alusrc,
  input  logic [3:0]       id_alucontrol,
  input  logic             id_regwrite,
  input  logic             stall,
  input  logic             flush,
  input  logic [RBITS-1:0] exmem_rd,
  input  logic             exmem_regwrite,
  input  logic [N-1:0]     exmem_result,
  input  logic [RBITS-1:0] memwb_rd,
  input  logic             memwb_regwrite,
  input  logic [N-1:0]     memwb_result,
  output logic             ex_valid,
  output logic [N-1:0]     a,
  output logic [N-1:0]     b,
  output logic [3:0]       ALUcontrol,
  output logic [RBITS-1:0] ex_rd,
  output logic             ex_regwrite,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  typedef struct packed {
    logic             valid;
    logic [RBITS-1:0] rn;
    logic [RBITS-1:0] rm;
    logic [RBITS-1:0] rd;
    logic [N-1:0]     rn_data;
    logic [N-1:0]     rm_data;
    logic [N-1:0]     imm;
    logic             alusrc;
    logic [3:0]       alucontrol;
    logic             regwrite;
  } stage_t;

  stage_t stage_d, stage_q;

  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid      = id_valid;
      stage_d.rn         = id_rn;
      stage_d.rm         = id_rm;
      stage_d.rd         = id_rd;
      stage_d.rn_data    = id_rn_data;
      stage_d.rm_data    = id_rm_data;
      stage_d.imm        = id_imm;
      stage_d.alusrc     = id_alusrc;
      stage_d.alucontrol = id_alucontrol;
      stage_d.regwrite   = id_regwrite;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values regardless of block order.
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  logic [N-1:0] opnd_a, opnd_b;
  fwd_sel_t     sel_a, sel_b;

  forward_unit #(.N(N), .RBITS(RBITS)) u_fwd_a (
    .src            (stage_q.rn),
    .rf_data        (stage_q.rn_data),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_result   (memwb_result),
    .operand        (opnd_a),
    .sel            (sel_a)
  );

  forward_unit #(.N(N), .RBITS(RBITS)) u_fwd_b (
    .src            (stage_q.rm),
    .rf_data        (stage_q.rm_data),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_result   (memwb_result),
    .operand        (opnd_b),
    .sel            (sel_b)
  );

  // An invalid stage presents a clean bubble: zero operands and AND, so the ALU sees y=0.
  always_comb begin
    ex_valid    = stage_q.valid;
    ex_rd       = stage_q.rd;
    a           = '0;
    b           = '0;
    ALUcontrol  = ALU_AND;
    ex_regwrite = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (stage_q.valid) begin
      a           = opnd_a;
      b           = stage_q.alusrc ? stage_q.imm : opnd_b;
      ALUcontrol  = stage_q.alucontrol;
      ex_regwrite = stage_q.regwrite;
      fwd_a       = sel_a;
      fwd_b       = sel_b;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed and randomized checks of alu_operand_stage against a behavioural
// model of the stage register and forwarding rules.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rn, id_rm, id_rd;
  logic [63:0] id_rn_data, id_rm_data, id_imm;
  logic        id_alusrc;
  logic [3:0]  id_alucontrol;
  logic        id_regwrite;
  logic        stall, flush;
  logic [4:0]  exmem_rd, memwb_rd;
  logic        exmem_regwrite, memwb_regwrite;
  logic [63:0] exmem_result, memwb_result;

  logic        ex_valid;
  logic [63:0] a, b;
  logic [3:0]  alu_ctl;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic [1:0]  fwd_a, fwd_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rn          (id_rn),
    .id_rm          (id_rm),
    .id_rd          (id_rd),
    .id_rn_data     (id_rn_data),
    .id_rm_data     (id_rm_data),
    .id_imm         (id_imm),
    .id_alusrc      (id_alusrc),
    .id_alucontrol  (id_alucontrol),
    .id_regwrite    (id_regwrite),
    .stall          (stall),
    .flush          (flush),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .exmem_result   (exmem_result),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .memwb_result   (memwb_result),
    .ex_valid       (ex_valid),
    .a              (a),
    .b              (b),
    .ALUcontrol     (alu_ctl),
    .ex_rd          (ex_rd),
    .ex_regwrite    (ex_regwrite),
    .fwd_a          (fwd_a),
    .fwd_b          (fwd_b)
  );

  // Model: the instruction currently latched in the stage.
  typedef struct {
    logic        valid;
    logic [4:0]  rn, rm, rd;
    logic [63:0] rn_data, rm_data, imm;
    logic        alusrc;
    logic [3:0]  ctl;
    logic        regwrite;
  } instr_t;

  instr_t m;

  task automatic model_clear();
    m = '{valid: 1'b0, rn: 5'd0, rm: 5'd0, rd: 5'd0, rn_data: 64'd0, rm_data: 64'd0,
          imm: 64'd0, alusrc: 1'b0, ctl: 4'd0, regwrite: 1'b0};
  endtask

  task automatic model_edge();
    if (reset || flush) begin
      model_clear();
    end else if (!stall) begin
      m = '{valid: id_valid, rn: id_rn, rm: id_rm, rd: id_rd, rn_data: id_rn_data,
            rm_data: id_rm_data, imm: id_imm, alusrc: id_alusrc, ctl: id_alucontrol,
            regwrite: id_regwrite};
    end
  endtask

  function automatic void resolve(input logic [4:0] src, input logic [63:0] rf,
                                  output logic [63:0] v, output logic [1:0] s);
    if (src == 5'd31) begin
      v = 64'd0; s = 2'd0;
    end else if (exmem_regwrite && exmem_rd == src && exmem_rd != 5'd31) begin
      v = exmem_result; s = 2'd2;
    end else if (memwb_regwrite && memwb_rd == src && memwb_rd != 5'd31) begin
      v = memwb_result; s = 2'd1;
    end else begin
      v = rf; s = 2'd0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    logic [63:0] va, vb, ea, eb;
    logic [1:0]  sa, sb;
    resolve(m.rn, m.rn_data, va, sa);
    resolve(m.rm, m.rm_data, vb, sb);
    ea = m.valid ? va : 64'd0;
    eb = !m.valid ? 64'd0 : (m.alusrc ? m.imm : vb);
    check({ctx, ".ex_valid"},    64'(ex_valid),    64'(m.valid));
    check({ctx, ".a"},           a,                ea);
    check({ctx, ".b"},           b,                eb);
    check({ctx, ".ALUcontrol"},  64'(alu_ctl),     m.valid ? 64'(m.ctl) : 64'd0);
    check({ctx, ".ex_rd"},       64'(ex_rd),       64'(m.rd));
    check({ctx, ".ex_regwrite"}, 64'(ex_regwrite), 64'(m.valid && m.regwrite));
    check({ctx, ".fwd_a"},       64'(fwd_a),       m.valid ? 64'(sa) : 64'd0);
    check({ctx, ".fwd_b"},       64'(fwd_b),       m.valid ? 64'(sb) : 64'd0);
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                          input logic [4:0] rd, input logic [63:0] rnd, input logic [63:0] rmd,
                          input logic [63:0] imm, input logic src, input logic [3:0] ctl,
                          input logic rw);
    id_valid = v; id_rn = rn; id_rm = rm; id_rd = rd;
    id_rn_data = rnd; id_rm_data = rmd; id_imm = imm;
    id_alusrc = src; id_alucontrol = ctl; id_regwrite = rw;
  endtask

  task automatic drive_fwd(input logic [4:0] erd, input logic erw, input logic [63:0] eres,
                           input logic [4:0] mrd, input logic mrw, input logic [63:0] mres);
    exmem_rd = erd; exmem_regwrite = erw; exmem_result = eres;
    memwb_rd = mrd; memwb_regwrite = mrw; memwb_result = mres;
  endtask

  // One rising edge, model update at the edge, then settle away from the edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  function automatic logic [4:0] rand_reg();
    case ($urandom_range(0, 4))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      3: return 5'd31;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] alu_y(input logic [63:0] x, input logic [63:0] y,
                                        input logic [3:0] op);
    case (op)
      4'd0: return x & y;
      4'd1: return x | y;
      4'd2: return x + y;
      4'd6: return x - y;
      4'd7: return y;
      default: return 64'd0;
    endcase
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0);
    drive_fwd(5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0);
    model_clear();
    step();
    step();
    check_all("init_reset");
    reset = 1'b0;

    // Plain load, no hazards.
    drive_id(1'b1, 5'd1, 5'd2, 5'd4, 64'd2, 64'd3, 64'd0, 1'b0, 4'd0, 1'b1);
    step();
    check_all("t2");
    check("t2.a_lit", a, 64'd2);
    check("t2.b_lit", b, 64'd3);
    check("t2.y_and", alu_y(a, b, alu_ctl), 64'd2);

    // EX/MEM beats MEM/WB; dropping EX/MEM falls back within the same cycle.
    drive_id(1'b1, 5'd5, 5'd5, 5'd6, 64'd100, 64'd200, 64'd0, 1'b0, 4'd2, 1'b1);
    step();
    drive_fwd(5'd5, 1'b1, 64'd7, 5'd5, 1'b1, 64'd9);
    #1;
    check_all("t3_exmem");
    check("t3.a_lit", a, 64'd7);
    check("t3.fwd_b_lit", 64'(fwd_b), 64'd2);
    exmem_regwrite = 1'b0;
    #1;
    check_all("t3_memwb");
    check("t3.b_lit", b, 64'd9);
    check("t3.fwd_a_lit", 64'(fwd_a), 64'd1);

    // Zero register is never forwarded; immediate overrides rm but fwd_b still reports.
    drive_id(1'b1, 5'd31, 5'd3, 5'd7, 64'd55, 64'd44, 64'd3, 1'b1, 4'd2, 1'b1);
    step();
    drive_fwd(5'd31, 1'b1, 64'hFF, 5'd3, 1'b1, 64'd123);
    #1;
    check_all("t4");
    check("t4.a_lit", a, 64'd0);
    check("t4.fwd_a_lit", 64'(fwd_a), 64'd0);
    check("t4.b_lit", b, 64'd3);
    check("t4.fwd_b_lit", 64'(fwd_b), 64'd1);

    // Async reset mid-cycle while stalled: outputs clear without a clock edge.
    drive_fwd(5'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0);
    stall = 1'b1;
    #1;
    reset = 1'b1;
    model_clear();
    #1;
    check_all("t1_async");
    check("t1.a_lit", a, 64'd0);
    step();
    check_all("t1_hold1");
    step();
    check_all("t1_hold2");
    reset = 1'b0;
    stall = 1'b0;

    // Stall holds across changing id_*, then stall+flush inserts a bubble.
    drive_id(1'b1, 5'd1, 5'd2, 5'd9, 64'd11, 64'd22, 64'd0, 1'b0, 4'd1, 1'b1);
    step();
    check_all("t5_load");
    stall = 1'b1;
    drive_id(1'b1, 5'd3, 5'd4, 5'd10, 64'd33, 64'd44, 64'd5, 1'b1, 4'd6, 1'b0);
    step();
    check_all("t5_stall1");
    drive_id(1'b0, 5'd7, 5'd8, 5'd12, 64'd77, 64'd88, 64'd6, 1'b0, 4'd7, 1'b0);
    step();
    check_all("t5_stall2");
    check("t5.a_lit", a, 64'd11);
    check("t5.ex_rd_lit", 64'(ex_rd), 64'd9);
    flush = 1'b1;
    step();
    check_all("t5_flush");
    check("t5.ex_valid_lit", 64'(ex_valid), 64'd0);
    check("t5.b_lit", b, 64'd0);
    stall = 1'b0;
    flush = 1'b0;

    // Back-to-back ADD then SUB.
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 64'd3, 64'd3, 64'd0, 1'b0, 4'd2, 1'b1);
    step();
    check_all("t6_add");
    check("t6.add_ctl", 64'(alu_ctl), 64'd2);
    check("t6.add_y", alu_y(a, b, alu_ctl), 64'd6);
    drive_id(1'b1, 5'd1, 5'd2, 5'd3, 64'd3, 64'd3, 64'd0, 1'b0, 4'd6, 1'b1);
    step();
    check_all("t6_sub");
    check("t6.sub_ctl", 64'(alu_ctl), 64'd6);
    check("t6.sub_y", alu_y(a, b, alu_ctl), 64'd0);

    // Randomized traffic with hazards, stalls, flushes and occasional async reset.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        model_clear();
        #1;
        check_all("rnd_reset");
        step();
        #1;
        reset = 1'b0;
      end
      drive_id(($urandom_range(0, 4) != 0), rand_reg(), rand_reg(), rand_reg(),
               rand64(), rand64(), rand64(), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      drive_fwd(rand_reg(), 1'($urandom_range(0, 1)), rand64(),
                rand_reg(), 1'($urandom_range(0, 1)), rand64());
      step();
      check_all("rnd_edge");
      drive_fwd(rand_reg(), 1'($urandom_range(0, 1)), rand64(),
                rand_reg(), 1'($urandom_range(0, 1)), rand64());
      #1;
      check_all("rnd_comb");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
